// File: rtl/apb_requester_if.sv
// rtl/apb_requester_if.sv - command, APB bus and response signal bundle for apb_requester
//
// Purpose: groups the command handshake, the APB requester bus and the
// response strobe into one interface.
// Modports:
//   master - the requester: takes cmd_* and completer returns, drives
//            cmd_ready, the APB request signals and rsp_*.
//   slave  - the environment: offers commands and acts as the APB completer.
// Signals: cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata,
//          psel/penable/pwrite/paddr/pwdata/pready/prdata/pslverr,
//          rsp_valid/rsp_rdata/rsp_error.

interface apb_requester_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_error;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  pready, prdata, pslverr,
    output cmd_ready,
    output psel, penable, pwrite, paddr, pwdata,
    output rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output pready, prdata, pslverr,
    input  cmd_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    input  rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester turning single commands into SETUP/ACCESS transfers
//
// Purpose: accepts one command at a time in IDLE, runs an APB transfer
// (SETUP for one cycle, ACCESS until pready), and reports completion with a
// one-cycle rsp_valid carrying read data and error status.
// Ports:
//   pclk     - bus clock, rising edge
//   preset_n - asynchronous active-low reset
//   bus      - apb_requester_if.master (command, APB bus, response)
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles with pready low (response with rsp_error=1).

module apb_requester #(
  parameter int ADDR_W         = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  apb_requester_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e            state_q;
  logic              cmd_ready_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_error_q;

`ifdef APB_TIMEOUT_EN
  logic [7:0]        wait_cnt_q;
`endif

  // An out-of-range TIMEOUT_CYCLES leaves this marker block in the hierarchy.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_cycles_out_of_range
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= 8'd0;
`endif
    end else begin
      // Response strobe lives for the first IDLE cycle only.
      rsp_valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            state_q     <= ST_SETUP;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= bus.cmd_write;
            paddr_q     <= bus.cmd_addr;
            pwdata_q    <= bus.cmd_write ? bus.cmd_wdata : '0;
          end
        end

        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt_q <= 8'd0;
`endif
        end

        ST_ACCESS: begin
          if (bus.pready) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            rsp_error_q <= bus.pslverr;
          end
`ifdef APB_TIMEOUT_EN
          // This edge would bring the low-pready count to TIMEOUT_CYCLES.
          else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end

        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - self-checking bench for apb_requester

module tb_apb_requester;

  localparam int TO = 16;

  typedef struct {
    logic       wr;
    logic [1:0] addr;
    logic [7:0] wdata;
    int         waits;
    logic [7:0] rdata;
    logic       err;
  } xfer_t;

  logic pclk;
  logic preset_n;
  int   checks;
  int   errors;

  // Expected values of held outputs, updated from the transfer rules.
  logic       exp_pwrite;
  logic [1:0] exp_paddr;
  logic [7:0] exp_pwdata;
  logic [7:0] exp_rdata;
  logic       exp_err;

  apb_requester_if #(.ADDR_W(2), .DATA_W(8)) bus ();

  apb_requester #(.ADDR_W(2), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic psel, input logic penable,
                           input logic rsp_valid, input logic cmd_ready);
    check({tag, "_psel"},      32'(bus.psel),      32'(psel));
    check({tag, "_penable"},   32'(bus.penable),   32'(penable));
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(rsp_valid));
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(cmd_ready));
    check({tag, "_pwrite"},    32'(bus.pwrite),    32'(exp_pwrite));
    check({tag, "_paddr"},     32'(bus.paddr),     32'(exp_paddr));
    check({tag, "_pwdata"},    32'(bus.pwdata),    32'(exp_pwdata));
  endtask

  task automatic drive_cmd(input xfer_t t);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = t.wr;
    bus.cmd_addr  = t.addr;
    bus.cmd_wdata = t.wdata;
  endtask

  function automatic xfer_t rand_xfer();
    xfer_t t;
    t.wr    = 1'($urandom);
    t.addr  = 2'($urandom_range(0, 2));
    t.wdata = 8'($urandom);
    t.waits = int'($urandom_range(0, 5));
    t.rdata = 8'($urandom);
    t.err   = 1'($urandom);
    return t;
  endfunction

  // Called just after a falling edge. Returns just after the falling edge of
  // the response cycle; when has_next, the next command is already offered.
  task automatic run_xfer(input string tag, input xfer_t t, input bit has_next, input xfer_t nxt);
    drive_cmd(t);
    check({tag, "_ready_before"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge pclk); #1;
    if (has_next) begin
      drive_cmd(nxt);
    end else begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 2'($urandom);
      bus.cmd_wdata = 8'($urandom);
    end
    bus.pready  = 1'($urandom);
    bus.prdata  = 8'($urandom);
    bus.pslverr = 1'($urandom);
    exp_pwrite = t.wr;
    exp_paddr  = t.addr;
    exp_pwdata = t.wr ? t.wdata : 8'h00;
    @(negedge pclk);
    check_bus({tag, "_setup"}, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= t.waits; i++) begin
      @(posedge pclk); #1;
      bus.pready  = (i == t.waits);
      bus.prdata  = (i == t.waits) ? t.rdata : 8'($urandom);
      bus.pslverr = (i == t.waits) ? t.err : 1'($urandom);
      @(negedge pclk);
      check_bus({tag, "_access"}, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    @(posedge pclk); #1;
    bus.pready  = 1'b0;
    bus.prdata  = 8'($urandom);
    bus.pslverr = 1'($urandom);
    exp_rdata = t.wr ? 8'h00 : t.rdata;
    exp_err   = t.err;
    @(negedge pclk);
    check_bus({tag, "_rsp"}, 1'b0, 1'b0, 1'b1, 1'b1);
    check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
    check({tag, "_rsp_error"}, 32'(bus.rsp_error), 32'(exp_err));
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk); #1;
      @(negedge pclk);
      check_bus(tag, 1'b0, 1'b0, 1'b0, 1'b1);
      check({tag, "_rdata_hold"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
      check({tag, "_error_hold"}, 32'(bus.rsp_error), 32'(exp_err));
    end
  endtask

  initial begin
    xfer_t a;
    xfer_t b;
    checks        = 0;
    errors        = 0;
    preset_n      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 2'd0;
    bus.cmd_wdata = 8'h00;
    bus.pready    = 1'b0;
    bus.prdata    = 8'h00;
    bus.pslverr   = 1'b0;
    exp_pwrite    = 1'b0;
    exp_paddr     = 2'd0;
    exp_pwdata    = 8'h00;
    exp_rdata     = 8'h00;
    exp_err       = 1'b0;

    // Reset state.
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    check_bus("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("reset_rsp_error", 32'(bus.rsp_error), 32'd0);
    preset_n = 1'b1;
    idle("post_reset", 1);

    // Write, zero wait states.
    a = '{wr: 1'b1, addr: 2'd1, wdata: 8'hA5, waits: 0, rdata: 8'h5A, err: 1'b0};
    run_xfer("wr0", a, 1'b0, a);
    idle("wr0_idle", 1);

    // Read, three wait states.
    a = '{wr: 1'b0, addr: 2'd2, wdata: 8'hFF, waits: 3, rdata: 8'h3C, err: 1'b0};
    run_xfer("rd3", a, 1'b0, a);
    idle("rd3_idle", 2);

    // Completer error on a write.
    a = '{wr: 1'b1, addr: 2'd0, wdata: 8'h77, waits: 1, rdata: 8'h99, err: 1'b1};
    run_xfer("err", a, 1'b0, a);
    idle("err_idle", 1);

    // Back-to-back writes with cmd_valid held high throughout.
    a = '{wr: 1'b1, addr: 2'd1, wdata: 8'h11, waits: 0, rdata: 8'h00, err: 1'b0};
    b = '{wr: 1'b1, addr: 2'd2, wdata: 8'h22, waits: 0, rdata: 8'h00, err: 1'b0};
    run_xfer("b2b_1", a, 1'b1, b);
    run_xfer("b2b_2", b, 1'b0, b);
    idle("b2b_idle", 1);

`ifdef APB_TIMEOUT_EN
    // pready on the edge that would reach the limit: completion wins.
    a = '{wr: 1'b0, addr: 2'd0, wdata: 8'h00, waits: TO - 1, rdata: 8'hC3, err: 1'b0};
    run_xfer("to_edge", a, 1'b0, a);
    idle("to_edge_idle", 1);

    // pready never arrives: abort after TO ACCESS cycles.
    a = '{wr: 1'b0, addr: 2'd1, wdata: 8'h00, waits: 0, rdata: 8'h00, err: 1'b0};
    drive_cmd(a);
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    exp_pwrite = 1'b0;
    exp_paddr  = 2'd1;
    exp_pwdata = 8'h00;
    @(negedge pclk);
    check_bus("to_setup", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) begin
      @(posedge pclk); #1;
      bus.prdata  = 8'($urandom);
      bus.pslverr = 1'b0;
      @(negedge pclk);
      check_bus("to_access", 1'b1, 1'b1, 1'b0, 1'b0);
    end
    @(posedge pclk); #1;
    exp_rdata = 8'h00;
    exp_err   = 1'b1;
    @(negedge pclk);
    check_bus("to_abort", 1'b0, 1'b0, 1'b1, 1'b1);
    check("to_abort_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("to_abort_error", 32'(bus.rsp_error), 32'd1);
    idle("to_idle", 1);
`else
    // Without the timeout, a long wait is simply sustained.
    a = '{wr: 1'b0, addr: 2'd2, wdata: 8'h00, waits: 40, rdata: 8'hE1, err: 1'b0};
    run_xfer("long_wait", a, 1'b0, a);
    idle("long_wait_idle", 1);
`endif

    // Reset during ACCESS: transfer dropped, no response.
    a = '{wr: 1'b1, addr: 2'd2, wdata: 8'h6B, waits: 0, rdata: 8'h00, err: 1'b0};
    drive_cmd(a);
    @(posedge pclk); #1;
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    exp_pwrite = 1'b1;
    exp_paddr  = 2'd2;
    exp_pwdata = 8'h6B;
    @(negedge pclk);
    check_bus("mid_setup", 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge pclk); #1;
    @(negedge pclk);
    check_bus("mid_access", 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    preset_n = 1'b0;
    #1;
    exp_pwrite = 1'b0;
    exp_paddr  = 2'd0;
    exp_pwdata = 8'h00;
    exp_rdata  = 8'h00;
    exp_err    = 1'b0;
    check_bus("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1);
    bus.pready = 1'b1;
    @(negedge pclk);
    preset_n = 1'b1;
    idle("mid_after", 3);
    bus.pready = 1'b0;

    // Randomised transfers, chained back-to-back at random.
    a = rand_xfer();
    for (int n = 0; n < 40; n++) begin
      bit chain;
      b = rand_xfer();
      chain = (n < 39) && ($urandom_range(0, 1) == 1);
      run_xfer("rand", a, chain, b);
      if (!chain) idle("rand_idle", int'($urandom_range(1, 2)));
      a = b;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
# apb_requester

APB requester (initiator) that drives the same 8-bit register interface our APB completers decode: it turns a single-entry command (select, write/read, data) into a full APB SETUP/ACCESS transfer. It honours pready wait states and returns read data and error status on a one-cycle response strobe. It sits between the test/control logic and the peripheral bus, as the initiator end for the payload and data-size register completers.

## Interface
- ADDR_W, 2: width of paddr and cmd_addr. Selects 0 = payload_0, 1 = payload_1, 2 = data_size.
- DATA_W, 8: width of pwdata, prdata, cmd_wdata and rsp_rdata.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with pready low. Used only when APB_TIMEOUT_EN is defined. Legal range is 1..255.
- pclk  in  1  bus clock. Everything is sampled on its rising edge.
- preset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  a command is offered.
- cmd_ready  out  1  the requester can accept a command. High only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register select.
- cmd_wdata  in  DATA_W  write data. Ignored for reads.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  completer ready.
- prdata  in  DATA_W  completer read data.
- pslverr  in  1  completer error.
- rsp_valid  out  1  one-cycle pulse when a transfer has completed.
- rsp_rdata  out  DATA_W  read data. 0 for writes and for aborted transfers.
- rsp_error  out  1  pslverr from the completion cycle, or a timeout abort.

## Operation
- FSM states are IDLE, SETUP and ACCESS. Every output is registered.
- IDLE: cmd_ready=1, psel=0, penable=0.
  - When cmd_valid && cmd_ready, the command is captured into pwrite/paddr/pwdata and the FSM goes to SETUP.
  - For a read, pwdata is driven to 0.
- SETUP: psel=1, penable=0. Lasts exactly one cycle, then the FSM goes to ACCESS.
- ACCESS: psel=1, penable=1.
  - While pready=0, the FSM stays in ACCESS with pwrite/paddr/pwdata held stable.
  - On an edge where pready=1:
    - capture prdata into rsp_rdata (reads only; writes load 0);
    - capture pslverr into rsp_error;
    - set rsp_valid=1;
    - drop psel and penable;
    - go to IDLE.
- prdata and pslverr are sampled only on the completion edge. Their values at any other time are ignored.
- rsp_valid is high for exactly one cycle, which is the first IDLE cycle. cmd_ready is also 1 in that cycle, so a pending command can be accepted in the same cycle.
- rsp_rdata and rsp_error hold their values until the next completion.
- Commands offered while cmd_ready=0 are not consumed. The offerer must hold cmd_valid and the command fields.
- pwrite/paddr/pwdata keep their last values in IDLE. Only psel/penable qualify the bus.

## Timing
- Reset (asynchronous): state=IDLE, cmd_ready=1, and all other outputs 0. This applies at any point, including mid-transfer: an in-flight transfer is dropped and no rsp_valid is generated.
- Minimum latency (no wait states), counting the accept edge as edge 0:
  - cycle 1: SETUP;
  - cycle 2: ACCESS, with pready=1 sampled at the end of the cycle;
  - cycle 3: rsp_valid=1 and cmd_ready=1.
- Each wait state (pready=0 in ACCESS) adds one cycle.
- Back-to-back commands run at a throughput of one transfer per 3 cycles. psel is low for the single IDLE cycle between transfers.
- If cmd_valid and completion happen on the same edge, the command is not accepted on that edge. It is accepted on the next edge, when cmd_ready=1.

## Configuration
- APB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ACCESS and increments on every ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES with pready still 0, the transfer is aborted: go to IDLE, rsp_valid=1, rsp_error=1, rsp_rdata=0.
  - If pready=1 arrives on the same edge as the count is reached, normal completion wins.
- APB_TIMEOUT_EN undefined: no counter is built and ACCESS waits indefinitely for pready.

## Test plan
- Write with zero wait states: cmd_write=1, cmd_addr=1, cmd_wdata=0xA5, pready=1.
  - psel=1/penable=0 at cycle 1, penable=1 at cycle 2, paddr=1 and pwdata=0xA5 stable in both cycles.
  - rsp_valid=1, rsp_error=0, rsp_rdata=0 at cycle 3.
- Read with 3 wait states: cmd_addr=2, pready low for 3 ACCESS cycles, prdata=0x3C on the completion edge.
  - ACCESS lasts 4 cycles; then rsp_valid=1 and rsp_rdata=0x3C.
- Error: pslverr=1 together with pready=1 on a write to addr 0 -> rsp_error=1 on the rsp_valid cycle.
- Back-to-back: cmd_valid held high for two writes (0x11, 0x22) -> the second SETUP starts one cycle after the first rsp_valid, and pwdata=0x22 in the second transfer.
- Reset mid-transfer: preset_n driven low during ACCESS -> psel, penable and rsp_valid go to 0 immediately; after release, cmd_ready=1 and no response is generated.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and pready held 0 -> after 16 ACCESS cycles, rsp_valid=1, rsp_error=1, rsp_rdata=0, psel=0.
